// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// width-dependent special-result constants.
package divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Callers truncate these to their own WIDTH (2..64).
  function automatic logic [63:0] all_ones(input int unsigned w);
    return {64{1'b1}} >> (64 - w);
  endfunction

  function automatic logic [63:0] min_val(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only if it did not go negative.
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_i < dvs_i always holds, so the difference fits WIDTH+1 bits signed
  // and its MSB alone tells whether the subtraction succeeded.
  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {1'b0, dvs_i};
  assign q_o     = ~trial[WIDTH];
  assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready handshakes,
// one operation in flight, divide-by-zero and signed-overflow flags.
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err_dz,
  output logic             err_ovf
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] Q_DZ   = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(min_val(WIDTH));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] work_q, work_d;   // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             err_dz_q, err_dz_d;
  logic             err_ovf_q, err_ovf_d;

  logic             eff_signed, dvd_neg, dvs_neg, is_dz, is_ovf;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (work_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign eff_signed = SIGNED_EN && op_signed;
  assign dvd_neg    = eff_signed && dividend[WIDTH-1];
  assign dvs_neg    = eff_signed && divisor[WIDTH-1];
  assign is_dz      = (divisor == '0);
  assign is_ovf     = eff_signed && (dividend == MIN_V) && (divisor == {WIDTH{1'b1}});

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    work_d    = work_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    quot_d    = quot_q;
    rmd_d     = rmd_q;
    err_dz_d  = err_dz_q;
    err_ovf_d = err_ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // The unsigned WIDTH-bit magnitude of MIN is exact, so MIN/1,
          // MIN/2 and MIN/MIN need no special handling.
          work_d    = dvd_neg ? -dividend : dividend;
          dvs_d     = dvs_neg ? -divisor : divisor;
          rem_d     = '0;
          quo_neg_d = dvd_neg ^ dvs_neg;
          rem_neg_d = dvd_neg;
          cnt_d     = CNT_W'(WIDTH - 1);
          err_dz_d  = 1'b0;
          err_ovf_d = 1'b0;
          if (is_dz) begin
            state_d  = ST_DONE;
            quot_d   = Q_DZ;
            rmd_d    = dividend;
            err_dz_d = 1'b1;
          end else if (is_ovf) begin
            state_d   = ST_DONE;
            quot_d    = MIN_V;
            rmd_d     = '0;
            err_ovf_d = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d  = step_rem;
        work_d = {work_q[WIDTH-2:0], step_q};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        quot_d  = quo_neg_q ? -work_q : work_q;
        rmd_d   = rem_neg_q ? -rem_q : rem_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      work_q    <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      quot_q    <= '0;
      rmd_q     <= '0;
      err_dz_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      work_q    <= work_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      quot_q    <= quot_d;
      rmd_q     <= rmd_d;
      err_dz_q  <= err_dz_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign err_dz    = err_dz_q;
  assign err_ovf   = err_ovf_q;

endmodule
